// File: rtl/array_pkg.sv
// Shared constants for the 2r1w 64-word array port scheduler.
package array_pkg;
  localparam int ADR_W   = 6;
  localparam int WORDS   = 64;
  localparam int IDW_DEF = 3;

  localparam int RD0 = 0;
  localparam int RD1 = 1;
  localparam int WR0 = 2;

  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction
endpackage

// File: rtl/array_port_scheduler_if.sv
// Requester-side bus and predecoder-side port outputs of the array scheduler.
interface array_port_scheduler_if
  import array_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = IDW_DEF
);
  logic                   stall;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_write;
  logic [NREQ*ADR_W-1:0]  req_adr;
  logic [NREQ-1:0]        req_ready;
  logic                   rd_enb_0;
  logic [ADR_W-1:0]       rd_adr_0;
  logic                   rd_enb_1;
  logic [ADR_W-1:0]       rd_adr_1;
  logic                   wr_enb_0;
  logic [ADR_W-1:0]       wr_adr_0;
  logic [IDW-1:0]         wr_id;
  logic                   rsp_valid_0;
  logic [IDW-1:0]         rsp_id_0;
  logic                   rsp_valid_1;
  logic [IDW-1:0]         rsp_id_1;

  modport master (
    output stall, req_valid, req_write, req_adr,
    input  req_ready, rd_enb_0, rd_adr_0, rd_enb_1, rd_adr_1,
           wr_enb_0, wr_adr_0, wr_id, rsp_valid_0, rsp_id_0, rsp_valid_1, rsp_id_1
  );

  modport slave (
    input  stall, req_valid, req_write, req_adr,
    output req_ready, rd_enb_0, rd_adr_0, rd_enb_1, rd_adr_1,
           wr_enb_0, wr_adr_0, wr_id, rsp_valid_0, rsp_id_0, rsp_valid_1, rsp_id_1
  );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after i_start, wrapping.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = 3
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_start,
  output logic            o_found,
  output logic [IW-1:0]   o_idx,
  output logic [NREQ-1:0] o_onehot
);
  logic [NREQ-1:0] w_ge;
  logic [NREQ-1:0] w_hi;
  logic [NREQ-1:0] w_sel;

  // Prefer requests at/after the pointer; otherwise wrap to the lowest index.
  always_comb begin
    w_ge = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_ge[i] = (IW'(i) >= i_start);
    end
    w_hi     = i_req & w_ge;
    w_sel    = (|w_hi) ? w_hi : i_req;
    o_onehot = w_sel & (~w_sel + NREQ'(1));
    o_found  = |i_req;
    o_idx    = '0;
    for (int i = 0; i < NREQ; i++) begin
      o_idx = o_idx | (o_onehot[i] ? IW'(i) : IW'(0));
    end
  end
endmodule

// File: rtl/array_port_scheduler.sv
// Round-robin scheduler mapping NREQ requesters onto two read ports and one write port.
module array_port_scheduler
  import array_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int RD_LAT = 2,
  parameter int IDW    = IDW_DEF
) (
  input logic                   clk,
  input logic                   reset,
  array_port_scheduler_if.slave bus
);
  logic [ADR_W-1:0] w_adr [NREQ];
  logic [NREQ-1:0]  w_wr_req, w_rd_elig, w_wr_oh, w_p0_oh, w_p1_oh;
  logic             w_wr_found, w_p0_found, w_p1_found;
  logic [IDW-1:0]   w_wr_idx, w_p0_idx, w_p1_idx, w_p1_start, w_rd_ptr_nxt;
  logic [ADR_W-1:0] w_wr_adr, w_p0_adr, w_p1_adr;

  logic [IDW-1:0]    r_wr_ptr, r_rd_ptr, r_wr_id;
  logic [2:0]        r_enb;
  logic [ADR_W-1:0]  r_adr [3];
  logic [IDW-1:0]    r_rd_id [2];
  logic [RD_LAT-1:0] r_pv0, r_pv1;
  logic [IDW-1:0]    r_pid0 [RD_LAT];
  logic [IDW-1:0]    r_pid1 [RD_LAT];

  for (genvar g = 0; g < NREQ; g++) begin : g_adr
    assign w_adr[g] = bus.req_adr[g*ADR_W +: ADR_W];
  end

  assign w_wr_req   = bus.req_valid & bus.req_write;
  assign w_p1_start = IDW'(wrap_inc(int'(w_p0_idx), NREQ));

  rr_pick #(.NREQ(NREQ), .IW(IDW)) u_pick_wr (
    .i_req(w_wr_req), .i_start(r_wr_ptr),
    .o_found(w_wr_found), .o_idx(w_wr_idx), .o_onehot(w_wr_oh)
  );
  rr_pick #(.NREQ(NREQ), .IW(IDW)) u_pick_rd0 (
    .i_req(w_rd_elig), .i_start(r_rd_ptr),
    .o_found(w_p0_found), .o_idx(w_p0_idx), .o_onehot(w_p0_oh)
  );
  rr_pick #(.NREQ(NREQ), .IW(IDW)) u_pick_rd1 (
    .i_req(w_rd_elig & ~w_p0_oh), .i_start(w_p1_start),
    .o_found(w_p1_found), .o_idx(w_p1_idx), .o_onehot(w_p1_oh)
  );

  // Winner addresses; reads hitting the winning write word wait a cycle (no bypass).
  always_comb begin
    w_wr_adr = '0;
    w_p0_adr = '0;
    w_p1_adr = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_wr_adr = w_wr_adr | ({ADR_W{w_wr_oh[i]}} & w_adr[i]);
      w_p0_adr = w_p0_adr | ({ADR_W{w_p0_oh[i]}} & w_adr[i]);
      w_p1_adr = w_p1_adr | ({ADR_W{w_p1_oh[i]}} & w_adr[i]);
    end
    w_rd_elig = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_rd_elig[i] = bus.req_valid[i] & ~bus.req_write[i] &
                     ~(w_wr_found & (w_adr[i] == w_wr_adr));
    end
  end

  // Read pointer follows the last read granted this cycle.
  always_comb begin
    if (w_p1_found) begin
      w_rd_ptr_nxt = IDW'(wrap_inc(int'(w_p1_idx), NREQ));
    end else if (w_p0_found) begin
      w_rd_ptr_nxt = IDW'(wrap_inc(int'(w_p0_idx), NREQ));
    end else begin
      w_rd_ptr_nxt = r_rd_ptr;
    end
  end

  assign bus.req_ready = {NREQ{~bus.stall}} & (w_wr_oh | w_p0_oh | w_p1_oh);

  // Port enables, held addresses/IDs and arbitration pointers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_enb      <= 3'b000;
      r_adr[RD0] <= '0;
      r_adr[RD1] <= '0;
      r_adr[WR0] <= '0;
      r_rd_id[0] <= '0;
      r_rd_id[1] <= '0;
      r_wr_id    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else begin
      r_enb[RD0] <= ~bus.stall & w_p0_found;
      r_enb[RD1] <= ~bus.stall & w_p1_found;
      r_enb[WR0] <= ~bus.stall & w_wr_found;
      if (!bus.stall && w_p0_found) begin
        r_adr[RD0] <= w_p0_adr;
        r_rd_id[0] <= w_p0_idx;
      end
      if (!bus.stall && w_p1_found) begin
        r_adr[RD1] <= w_p1_adr;
        r_rd_id[1] <= w_p1_idx;
      end
      if (!bus.stall && w_wr_found) begin
        r_adr[WR0] <= w_wr_adr;
        r_wr_id    <= w_wr_idx;
        r_wr_ptr   <= IDW'(wrap_inc(int'(w_wr_idx), NREQ));
      end
      if (!bus.stall) begin
        r_rd_ptr <= w_rd_ptr_nxt;
      end
    end
  end

  // Read-response shift registers, one {valid,id} stage per cycle of array latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pv0 <= '0;
      r_pv1 <= '0;
      for (int k = 0; k < RD_LAT; k++) begin
        r_pid0[k] <= '0;
        r_pid1[k] <= '0;
      end
    end else begin
      r_pv0[0]  <= r_enb[RD0];
      r_pv1[0]  <= r_enb[RD1];
      r_pid0[0] <= r_rd_id[0];
      r_pid1[0] <= r_rd_id[1];
      for (int k = 1; k < RD_LAT; k++) begin
        r_pv0[k]  <= r_pv0[k-1];
        r_pv1[k]  <= r_pv1[k-1];
        r_pid0[k] <= r_pid0[k-1];
        r_pid1[k] <= r_pid1[k-1];
      end
    end
  end

  assign bus.rd_enb_0    = r_enb[RD0];
  assign bus.rd_adr_0    = r_adr[RD0];
  assign bus.rd_enb_1    = r_enb[RD1];
  assign bus.rd_adr_1    = r_adr[RD1];
  assign bus.wr_enb_0    = r_enb[WR0];
  assign bus.wr_adr_0    = r_adr[WR0];
  assign bus.wr_id       = r_wr_id;
  assign bus.rsp_valid_0 = r_pv0[RD_LAT-1];
  assign bus.rsp_id_0    = r_pid0[RD_LAT-1];
  assign bus.rsp_valid_1 = r_pv1[RD_LAT-1];
  assign bus.rsp_id_1    = r_pid1[RD_LAT-1];
endmodule

// File: tb/tb_array_port_scheduler.sv
// Directed bench for array_port_scheduler with NREQ=4, RD_LAT=2.
module tb_array_port_scheduler;
  localparam int NREQ   = 4;
  localparam int RD_LAT = 2;
  localparam int IDW    = 3;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  array_port_scheduler_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  array_port_scheduler #(.NREQ(NREQ), .RD_LAT(RD_LAT), .IDW(IDW)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] v, input logic [3:0] w,
                       input logic [5:0] a0, input logic [5:0] a1,
                       input logic [5:0] a2, input logic [5:0] a3);
    bus.req_valid = v;
    bus.req_write = w;
    bus.req_adr   = {a3, a2, a1, a0};
    #1;
  endtask

  function automatic logic [2:0] enb_vec();
    return {bus.rd_enb_0, bus.rd_enb_1, bus.wr_enb_0};
  endfunction

  function automatic logic [1:0] rsp_vec();
    return {bus.rsp_valid_0, bus.rsp_valid_1};
  endfunction

  initial begin
    logic [3:0] exp_rdy [4];
    logic [5:0] exp_a0  [4];
    logic [5:0] exp_a1  [4];
    n_checks  = 0;
    n_errors  = 0;
    reset     = 1'b1;
    bus.stall = 1'b0;
    drive(4'b0000, 4'b0000, 6'd0, 6'd0, 6'd0, 6'd0);

    repeat (2) tick();
    check("rst_enb", 32'(enb_vec()), 32'd0);
    check("rst_adr", 32'({bus.rd_adr_0, bus.rd_adr_1, bus.wr_adr_0}), 32'd0);
    check("rst_ids", 32'({bus.wr_id, bus.rsp_id_0, bus.rsp_id_1}), 32'd0);
    check("rst_rsp", 32'(rsp_vec()), 32'd0);
    reset = 1'b0;
    repeat (2) tick();
    check("idle_enb", 32'(enb_vec()), 32'd0);
    check("idle_rsp", 32'(rsp_vec()), 32'd0);
    check("idle_rdy", 32'(bus.req_ready), 32'd0);

    // Two reads: req0 adr 5, req2 adr 9.
    drive(4'b0101, 4'b0000, 6'd5, 6'd0, 6'd9, 6'd0);
    check("rd2_rdy", 32'(bus.req_ready), 32'b0101);
    tick();
    check("rd2_enb", 32'(enb_vec()), 32'b110);
    check("rd2_adr0", 32'(bus.rd_adr_0), 32'd5);
    check("rd2_adr1", 32'(bus.rd_adr_1), 32'd9);
    drive(4'b0000, 4'b0000, 6'd0, 6'd0, 6'd0, 6'd0);
    tick();
    check("rd2_rsp_early", 32'(rsp_vec()), 32'b00);
    tick();
    check("rd2_rsp", 32'(rsp_vec()), 32'b11);
    check("rd2_rsp_ids", 32'({bus.rsp_id_0, bus.rsp_id_1}), 32'({3'd0, 3'd2}));
    tick();
    check("rd2_rsp_done", 32'(rsp_vec()), 32'b00);

    // Reads from rd_ptr=3, then reset with responses in flight.
    drive(4'b1111, 4'b0000, 6'd1, 6'd2, 6'd3, 6'd4);
    check("mr_rdy0", 32'(bus.req_ready), 32'b1001);
    tick();
    check("mr_adr", 32'({bus.rd_adr_0, bus.rd_adr_1}), 32'({6'd4, 6'd1}));
    check("mr_rdy1", 32'(bus.req_ready), 32'b0110);
    tick();
    drive(4'b0000, 4'b0000, 6'd0, 6'd0, 6'd0, 6'd0);
    tick();
    check("mr_rsp", 32'(rsp_vec()), 32'b11);
    check("mr_rsp_ids", 32'({bus.rsp_id_0, bus.rsp_id_1}), 32'({3'd3, 3'd0}));
    reset = 1'b1;
    #1;
    check("mr_rsp_async", 32'(rsp_vec()), 32'b00);
    check("mr_enb_async", 32'(enb_vec()), 32'b000);
    tick();
    reset = 1'b0;
    tick();
    check("mr_rsp_post0", 32'(rsp_vec()), 32'b00);
    tick();
    check("mr_rsp_post1", 32'(rsp_vec()), 32'b00);

    // All four requesters read every cycle.
    exp_rdy = '{4'b0011, 4'b1100, 4'b0011, 4'b1100};
    exp_a0  = '{6'd16, 6'd18, 6'd16, 6'd18};
    exp_a1  = '{6'd17, 6'd19, 6'd17, 6'd19};
    drive(4'b1111, 4'b0000, 6'd16, 6'd17, 6'd18, 6'd19);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("all_rdy%0d", k), 32'(bus.req_ready), 32'(exp_rdy[k]));
      tick();
      check($sformatf("all_enb%0d", k), 32'(enb_vec()), 32'b110);
      check($sformatf("all_adr%0d", k), 32'({bus.rd_adr_0, bus.rd_adr_1}),
            32'({exp_a0[k], exp_a1[k]}));
    end
    drive(4'b0000, 4'b0000, 6'd0, 6'd0, 6'd0, 6'd0);

    // Writers 1 and 3 held continuously.
    drive(4'b1010, 4'b1010, 6'd0, 6'd33, 6'd0, 6'd35);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("wr_rdy%0d", k), 32'(bus.req_ready), (k % 2 == 1) ? 32'b1000 : 32'b0010);
      tick();
      check($sformatf("wr_enb%0d", k), 32'(bus.wr_enb_0), 32'd1);
      check($sformatf("wr_id%0d", k), 32'(bus.wr_id), (k % 2 == 1) ? 32'd3 : 32'd1);
      check($sformatf("wr_adr%0d", k), 32'(bus.wr_adr_0), (k % 2 == 1) ? 32'd35 : 32'd33);
    end
    drive(4'b0000, 4'b0000, 6'd0, 6'd0, 6'd0, 6'd0);
    tick();
    check("wr_idle_enb", 32'(bus.wr_enb_0), 32'd0);
    check("wr_adr_hold", 32'(bus.wr_adr_0), 32'd35);

    // Read/write conflict on word 12.
    drive(4'b0011, 4'b0010, 6'd12, 6'd12, 6'd0, 6'd0);
    check("cf_rdy0", 32'(bus.req_ready), 32'b0010);
    tick();
    check("cf_enb0", 32'(enb_vec()), 32'b001);
    check("cf_wadr", 32'(bus.wr_adr_0), 32'd12);
    drive(4'b0001, 4'b0000, 6'd12, 6'd12, 6'd0, 6'd0);
    check("cf_rdy1", 32'(bus.req_ready), 32'b0001);
    tick();
    check("cf_enb1", 32'(enb_vec()), 32'b100);
    check("cf_radr", 32'(bus.rd_adr_0), 32'd12);
    drive(4'b0000, 4'b0000, 6'd0, 6'd0, 6'd0, 6'd0);

    // Stall with everything pending (rd_ptr=1, wr_ptr=2).
    bus.stall = 1'b1;
    drive(4'b1111, 4'b0100, 6'd20, 6'd21, 6'd40, 6'd23);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("st_rdy%0d", k), 32'(bus.req_ready), 32'd0);
      tick();
      check($sformatf("st_enb%0d", k), 32'(enb_vec()), 32'b000);
    end
    check("st_adr_hold", 32'(bus.rd_adr_0), 32'd12);
    bus.stall = 1'b0;
    #1;
    check("st_rel_rdy", 32'(bus.req_ready), 32'b1110);
    tick();
    check("st_rel_enb", 32'(enb_vec()), 32'b111);
    check("st_rel_radr", 32'({bus.rd_adr_0, bus.rd_adr_1}), 32'({6'd21, 6'd23}));
    check("st_rel_wr", 32'({bus.wr_adr_0, bus.wr_id}), 32'({6'd40, 3'd2}));
    drive(4'b0000, 4'b0000, 6'd0, 6'd0, 6'd0, 6'd0);
    tick();
    tick();
    check("st_rsp", 32'(rsp_vec()), 32'b11);
    check("st_rsp_ids", 32'({bus.rsp_id_0, bus.rsp_id_1}), 32'({3'd1, 3'd3}));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/array_port_scheduler.md
Name: array_port_scheduler

Overview:
- Shares the 2r1w 64-word array among NREQ requesters. Maps read and write requests onto the two read ports and the one write port that feed the per-port address predecoders.
- Uses round-robin arbitration per port class.
- Registers the port enables and addresses, and returns a read-response valid/ID to the requester after a fixed array latency.
- Sits between requester logic and the address/clock predecode stage.

Parameters:
- NREQ, 4, number of requesters (2..8)
- ADR_W, 6, address width (64 words)
- RD_LAT, 2, cycles from port enable asserted to read data valid at array output (1..4)
- IDW, 3, requester-ID width (must satisfy 2^IDW >= NREQ)

Ports:
- clk  in  1  array clock
- reset  in  1  asynchronous active-high reset
- stall  in  1  when high: no grants, no port enables
- req_valid  in  NREQ  request valid per requester
- req_write  in  NREQ  1=write, 0=read
- req_adr  in  NREQ*ADR_W  address; requester i at bits [i*ADR_W +: ADR_W]
- req_ready  out  NREQ  grant; transfer occurs when valid&ready (combinational)
- rd_enb_0  out  1  read port 0 enable
- rd_adr_0  out  ADR_W  read port 0 address
- rd_enb_1  out  1  read port 1 enable
- rd_adr_1  out  ADR_W  read port 1 address
- wr_enb_0  out  1  write port enable
- wr_adr_0  out  ADR_W  write port address
- wr_id  out  IDW  ID of granted writer, aligned with wr_enb_0 (steers write data mux)
- rsp_valid_0  out  1  read port 0 data valid
- rsp_id_0  out  IDW  requester owning rsp 0
- rsp_valid_1  out  1  read port 1 data valid
- rsp_id_1  out  IDW  requester owning rsp 1

Behaviour:
- Reset:
  - all enables, addresses, wr_id, rsp_valid_*, and rsp_id_* are 0.
  - rd_ptr and wr_ptr are 0.
  - the response pipeline is cleared.
  - Reset mid-operation drops in-flight responses with no replay.
- Requester rule: one request per requester per cycle. valid, write, and adr are held stable until ready.
- Write arbitration:
  - Among (valid & write), pick the first index at or after wr_ptr, with modulo NREQ wrap.
  - The winner gets ready. wr_ptr becomes winner+1 (wrapping NREQ-1 -> 0).
  - wr_ptr is unchanged if there is no winner.
- Read arbitration:
  - Eligible reads are (valid & ~write) with address not equal to this cycle's winning write address.
  - Conflicting reads are not granted. They retry next cycle, so no bypass exists and no same-cycle read/write overlap to one word occurs.
  - First eligible index at or after rd_ptr goes to port 0. The next eligible index after that goes to port 1.
  - rd_ptr becomes (last granted index)+1, mod NREQ. It is unchanged if there are no grants.
- Two reads to the same address may be granted on both ports in the same cycle. This is legal.
- stall=1: req_ready=0. The next-edge enables are 0. Pointers hold.
- Latency:
  - Grant in cycle N gives enb/adr/wr_id registered, valid in cycle N+1.
  - A read enable in cycle N+1 gives rsp_valid/rsp_id in cycle N+1+RD_LAT.
  - The pipeline is an RD_LAT-deep shift register of {valid, id} per read port, so it sustains 2 reads per cycle back-to-back.
- Addresses are held at their previous value when the enable is 0. Downstream gates with the enable.

Decomposition:
- Shared package array_pkg holds:
  - ADR_W=6, WORDS=64, IDW default
  - port index constants RD0=0, RD1=1, WR0=2
- Sub-module rr_pick, a combinational round-robin picker:
  - inputs: request mask [NREQ] and start pointer
  - outputs: found, index, one-hot
- It is instantiated three times: write, read port 0, and read port 1. The read port 1 instance takes the port 0 winner masked out and its start at the port 0 winner +1.
- The top holds the pointers, output registers, and response pipelines.

Test Plan (NREQ=4, RD_LAT=2):
- Reset, then idle -> all outputs 0. Assert reset mid-stream with rsp pending -> rsp_valid_* drop to 0 immediately and stay 0 after release.
- Reads req0 adr 5 and req2 adr 9 in cycle 0 -> ready=0101. Cycle 1: rd_enb_0=1 adr 5, rd_enb_1=1 adr 9. Cycle 3: rsp_valid_0 id 0, rsp_valid_1 id 2.
- All 4 requesters read every cycle for 4 cycles -> grant pairs {0,1},{2,3},{0,1},{2,3}. No requester waits more than 1 cycle.
- Writes from req1 and req3 held continuously -> wr grants alternate 1,3,1,3. wr_id matches and wr_enb_0 is high every cycle from cycle 1.
- Write req1 adr 12 plus read req0 adr 12 in the same cycle -> only req1 granted. Read granted next cycle (once no write to 12 wins) with rd_adr_0=12.
- stall=1 for 3 cycles with pending requests -> req_ready=0 and enables 0. Release -> grants resume from the unchanged pointers.
